// File: rtl/count_trend_monitor.sv
// rtl/count_trend_monitor.sv - step classifier and statistics for an observed up/down/hold counter
//
// Optional build macro: COUNT_TREND_DIRCHG_EN (adds dir_change output)
//
// Ports:
//   CLOCK      in   system clock, rising edge
//   Reset      in   synchronous active-high reset
//   count      in   WIDTH  observed counter value
//   Clear      in   synchronous clear of max/min/jump_cnt/hold run/stall
//   direction  out  2      00 none/jump, 01 up, 10 down, 11 hold
//   wrap_up    out  1      pulse on all-ones -> 0
//   wrap_dn    out  1      pulse on 0 -> all-ones
//   jump       out  1      pulse on any illegal step
//   jump_cnt   out  JCNT_W saturating jump count
//   max_seen   out  WIDTH  largest sample since reset/Clear
//   min_seen   out  WIDTH  smallest sample since reset/Clear
//   stall      out  1      high while hold run >= STALL_LIMIT
//   dir_change out  1      (macro only) pulse when move direction reverses
module count_trend_monitor #(
    parameter int WIDTH       = 5,
    parameter int STALL_LIMIT = 8,
    parameter int JCNT_W      = 8
) (
    input  logic              CLOCK,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  count,
    input  logic              Clear,
    output logic [1:0]        direction,
    output logic              wrap_up,
    output logic              wrap_dn,
    output logic              jump,
    output logic [JCNT_W-1:0] jump_cnt,
    output logic [WIDTH-1:0]  max_seen,
    output logic [WIDTH-1:0]  min_seen,
    output logic              stall
`ifdef COUNT_TREND_DIRCHG_EN
    ,
    output logic              dir_change
`endif
);

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [1:0]       DIR_NONE = 2'b00;
    localparam logic [1:0]       DIR_UP   = 2'b01;
    localparam logic [1:0]       DIR_DN   = 2'b10;
    localparam logic [1:0]       DIR_HOLD = 2'b11;
    localparam logic [WIDTH-1:0] ONES     = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [7:0]       STALL_LIM8 = 8'(STALL_LIMIT);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   prev, prev_nxt;
    logic [1:0]         dir_nxt;
    logic               wrap_up_nxt, wrap_dn_nxt, jump_nxt, stall_nxt;
    logic [JCNT_W-1:0]  jcnt_nxt;
    logic [WIDTH-1:0]   max_nxt, min_nxt;
    logic [7:0]         hold_run, run_nxt, run_inc;
`ifdef COUNT_TREND_DIRCHG_EN
    logic [1:0]         last_dir, last_dir_nxt;
    logic               dchg_nxt;
`endif

    // Hold run saturates at 255 so a long stall never wraps back below the limit.
    assign run_inc = (hold_run == 8'hFF) ? hold_run : hold_run + 8'd1;

    always_comb begin
        state_nxt   = state;
        prev_nxt    = prev;
        dir_nxt     = direction;
        wrap_up_nxt = 1'b0;
        wrap_dn_nxt = 1'b0;
        jump_nxt    = 1'b0;
        jcnt_nxt    = jump_cnt;
        max_nxt     = max_seen;
        min_nxt     = min_seen;
        run_nxt     = hold_run;
        stall_nxt   = stall;
`ifdef COUNT_TREND_DIRCHG_EN
        last_dir_nxt = last_dir;
        dchg_nxt     = 1'b0;
`endif

        case (state)
            INIT: begin
                prev_nxt  = count;
                max_nxt   = count;
                min_nxt   = count;
                dir_nxt   = DIR_NONE;
                state_nxt = TRACK;
            end
            default: begin
                prev_nxt = count;
                if (count > max_seen) max_nxt = count;
                if (count < min_seen) min_nxt = count;

                if (count == prev) begin
                    dir_nxt   = DIR_HOLD;
                    run_nxt   = run_inc;
                    stall_nxt = (run_inc >= STALL_LIM8);
                end else begin
                    run_nxt   = 8'd0;
                    stall_nxt = 1'b0;
                    // Wraps are tested before +1/-1 so they raise their own pulse.
                    if (prev == ONES && count == ZERO) begin
                        wrap_up_nxt = 1'b1;
                        dir_nxt     = DIR_UP;
                    end else if (prev == ZERO && count == ONES) begin
                        wrap_dn_nxt = 1'b1;
                        dir_nxt     = DIR_DN;
                    end else if (count == prev + WIDTH'(1)) begin
                        dir_nxt = DIR_UP;
                    end else if (count == prev - WIDTH'(1)) begin
                        dir_nxt = DIR_DN;
                    end else begin
                        jump_nxt = 1'b1;
                        dir_nxt  = DIR_NONE;
                        if (jump_cnt != '1) jcnt_nxt = jump_cnt + JCNT_W'(1);
                    end
                end
            end
        endcase

`ifdef COUNT_TREND_DIRCHG_EN
        // Only real moves (including wraps) update last_dir; holds and jumps leave it.
        if (state == TRACK && (dir_nxt == DIR_UP || dir_nxt == DIR_DN)) begin
            dchg_nxt     = (last_dir != DIR_NONE) && (last_dir != dir_nxt);
            last_dir_nxt = dir_nxt;
        end
`endif

        // Clear overrides statistics but leaves classification and prev alone.
        if (Clear) begin
            max_nxt   = count;
            min_nxt   = count;
            jcnt_nxt  = '0;
            run_nxt   = 8'd0;
            stall_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (Reset) begin
            state     <= INIT;
            prev      <= '0;
            direction <= DIR_NONE;
            wrap_up   <= 1'b0;
            wrap_dn   <= 1'b0;
            jump      <= 1'b0;
            jump_cnt  <= '0;
            max_seen  <= '0;
            min_seen  <= '0;
            hold_run  <= 8'd0;
            stall     <= 1'b0;
`ifdef COUNT_TREND_DIRCHG_EN
            last_dir   <= DIR_NONE;
            dir_change <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            direction <= dir_nxt;
            wrap_up   <= wrap_up_nxt;
            wrap_dn   <= wrap_dn_nxt;
            jump      <= jump_nxt;
            jump_cnt  <= jcnt_nxt;
            max_seen  <= max_nxt;
            min_seen  <= min_nxt;
            hold_run  <= run_nxt;
            stall     <= stall_nxt;
`ifdef COUNT_TREND_DIRCHG_EN
            last_dir   <= last_dir_nxt;
            dir_change <= dchg_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_count_trend_monitor.sv
// tb/tb_count_trend_monitor.sv - directed self-checking bench for count_trend_monitor
module tb_count_trend_monitor;

    logic       CLOCK = 1'b0;
    logic       Reset;
    logic [4:0] count;
    logic       Clear;
    logic [1:0] direction;
    logic       wrap_up, wrap_dn, jump, stall;
    logic [7:0] jump_cnt;
    logic [4:0] max_seen, min_seen;
`ifdef COUNT_TREND_DIRCHG_EN
    logic       dir_change;
`endif

    int n_checks = 0;
    int n_errors = 0;

    count_trend_monitor #(.WIDTH(5), .STALL_LIMIT(8), .JCNT_W(8)) dut (
        .CLOCK     (CLOCK),
        .Reset     (Reset),
        .count     (count),
        .Clear     (Clear),
        .direction (direction),
        .wrap_up   (wrap_up),
        .wrap_dn   (wrap_dn),
        .jump      (jump),
        .jump_cnt  (jump_cnt),
        .max_seen  (max_seen),
        .min_seen  (min_seen),
        .stall     (stall)
`ifdef COUNT_TREND_DIRCHG_EN
        ,
        .dir_change(dir_change)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are read there too.
    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic step(input logic [4:0] c, input logic clr);
        count = c;
        Clear = clr;
        tick();
        Clear = 1'b0;
    endtask

    task automatic expect_all(input string tag, input logic [1:0] d, input logic wu, input logic wd,
                              input logic jp, input logic [7:0] jc, input logic [4:0] mx,
                              input logic [4:0] mn, input logic st);
        check({tag, ".direction"}, 32'(direction), 32'(d));
        check({tag, ".wrap_up"},   32'(wrap_up),   32'(wu));
        check({tag, ".wrap_dn"},   32'(wrap_dn),   32'(wd));
        check({tag, ".jump"},      32'(jump),      32'(jp));
        check({tag, ".jump_cnt"},  32'(jump_cnt),  32'(jc));
        check({tag, ".max_seen"},  32'(max_seen),  32'(mx));
        check({tag, ".min_seen"},  32'(min_seen),  32'(mn));
        check({tag, ".stall"},     32'(stall),     32'(st));
    endtask

    initial begin
        Reset = 1'b1;
        Clear = 1'b0;
        count = 5'd0;
        tick();
        tick();
        expect_all("reset", 2'b00, 0, 0, 0, 8'd0, 5'd0, 5'd0, 0);

        // Hold at 0: edge 1 is INIT, edges 2..10 are hold steps 1..9.
        Reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step(5'd0, 1'b0);
            expect_all($sformatf("hold%0d", i), (i == 1) ? 2'b00 : 2'b11, 0, 0, 0, 8'd0,
                       5'd0, 5'd0, (i >= 9));
        end

        // 0 -> 29 is an illegal step, then a clean up run through the wrap.
        step(5'd29, 1'b0); expect_all("up29", 2'b00, 0, 0, 1, 8'd1, 5'd29, 5'd0, 0);
        step(5'd30, 1'b0); expect_all("up30", 2'b01, 0, 0, 0, 8'd1, 5'd30, 5'd0, 0);
        step(5'd31, 1'b0); expect_all("up31", 2'b01, 0, 0, 0, 8'd1, 5'd31, 5'd0, 0);
        step(5'd0,  1'b0); expect_all("up0",  2'b01, 1, 0, 0, 8'd1, 5'd31, 5'd0, 0);
        step(5'd1,  1'b0); expect_all("up1",  2'b01, 0, 0, 0, 8'd1, 5'd31, 5'd0, 0);

        // Down run through the wrap.
        step(5'd2,  1'b0); expect_all("dn2",  2'b01, 0, 0, 0, 8'd1, 5'd31, 5'd0, 0);
        step(5'd1,  1'b0); expect_all("dn1",  2'b10, 0, 0, 0, 8'd1, 5'd31, 5'd0, 0);
        step(5'd0,  1'b0); expect_all("dn0",  2'b10, 0, 0, 0, 8'd1, 5'd31, 5'd0, 0);
        step(5'd31, 1'b0); expect_all("dn31", 2'b10, 0, 1, 0, 8'd1, 5'd31, 5'd0, 0);
        step(5'd30, 1'b0); expect_all("dn30", 2'b10, 0, 0, 0, 8'd1, 5'd31, 5'd0, 0);

        // 30 -> 5 is a jump, but Clear on the same edge leaves jump_cnt at 0.
        step(5'd5,  1'b1); expect_all("clrjump", 2'b00, 0, 0, 1, 8'd0, 5'd5, 5'd5, 0);
        step(5'd12, 1'b0); expect_all("jump12",  2'b00, 0, 0, 1, 8'd1, 5'd12, 5'd5, 0);
        step(5'd3,  1'b0); expect_all("jump3",   2'b00, 0, 0, 1, 8'd2, 5'd12, 5'd3, 0);
        step(5'd3,  1'b1); expect_all("clr3",    2'b11, 0, 0, 0, 8'd0, 5'd3, 5'd3, 0);

        // Clear also restarts the hold run: 7 more holds must not stall, the 8th must.
        for (int i = 1; i <= 8; i++) begin
            step(5'd3, 1'b0);
            check($sformatf("clrrun%0d.stall", i), 32'(stall), 32'(i >= 8));
        end

        // 300 alternating jumps 0,16,...: counter saturates at 255.
        for (int i = 0; i < 300; i++) begin
            step((i % 2 == 0) ? 5'd0 : 5'd16, 1'b0);
            check($sformatf("sat%0d.jump", i), 32'(jump), 32'd1);
            check($sformatf("sat%0d.jump_cnt", i), 32'(jump_cnt), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
        end
        check("sat.max_seen", 32'(max_seen), 32'd16);
        check("sat.min_seen", 32'(min_seen), 32'd0);

        // Reset mid-run, release on 4: INIT edge, no false jump.
        step(5'd17, 1'b0); expect_all("pre17", 2'b01, 0, 0, 0, 8'd255, 5'd17, 5'd0, 0);
        Reset = 1'b1;
        step(5'd17, 1'b0); expect_all("midrst", 2'b00, 0, 0, 0, 8'd0, 5'd0, 5'd0, 0);
        Reset = 1'b0;
        step(5'd4, 1'b0);  expect_all("init4", 2'b00, 0, 0, 0, 8'd0, 5'd4, 5'd4, 0);
        step(5'd5, 1'b0);  expect_all("trk5",  2'b01, 0, 0, 0, 8'd0, 5'd5, 5'd4, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
